ysyx_23060187_ifu: RTL

Instruction fetch unit for the multi-cycle NPC core. It holds the PC and issues one instruction-memory read per instruction. It presents the returned instruction to the IDU over the IFU→IDU valid/ready handshake, then waits for the back end to return the next PC before fetching again. Exactly one instruction is in flight at any time; this block is the transmitter side of the `IFU_IDU_valid` / `IDU_IFU_ready` / `IFU_inst` interface.

---
 rtl/ysyx_23060187_ifu_if.sv | 43 ++++
 rtl/ysyx_23060187_ifu.sv | 82 ++++++++
 2 files changed

// File: rtl/ysyx_23060187_ifu_if.sv
// IFU bus bundle: instruction-memory request/response, IFU->IDU handoff
// and the next-PC return path from the back end.
interface ysyx_23060187_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        IFU_IDU_valid;
  logic        IDU_IFU_ready;
  logic [31:0] IFU_inst;
  logic [31:0] IFU_pc;
  logic        npc_valid;
  logic [31:0] npc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    output IFU_IDU_valid,
    input  IDU_IFU_ready,
    output IFU_inst,
    output IFU_pc,
    input  npc_valid,
    input  npc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_resp_valid,
    output imem_resp_data,
    input  IFU_IDU_valid,
    output IDU_IFU_ready,
    input  IFU_inst,
    input  IFU_pc,
    output npc_valid,
    output npc
  );
endinterface

// File: rtl/ysyx_23060187_ifu.sv
// Multi-cycle instruction fetch unit: one instruction in flight, fetched,
// handed to the IDU, then held until the back end returns the next PC.
module ysyx_23060187_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060187_ifu_if.master         bus,
  output logic [31:0]                 fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_EXEC  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      inst_pc_q   <= RESET_PC;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Each input is only honoured in the one state that owns its handshake.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          inst_d    = bus.imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.IDU_IFU_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.npc_valid) begin
          pc_d    = bus.npc & 32'hFFFF_FFFC;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state_q == S_FETCH);
  assign bus.imem_addr      = pc_q;
  assign bus.IFU_IDU_valid  = (state_q == S_VALID);
  assign bus.IFU_inst       = inst_q;
  assign bus.IFU_pc         = inst_pc_q;
  assign fetch_cnt          = fetch_cnt_q;

endmodule
